// File: rtl/keylock_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : keylock_ctrl_param
//  Purpose  : Parametrised keypad lock controller. Buffers entered digits,
//             compares them against an internally held code, supports code
//             reprogramming (old / new / confirm), failed-attempt lockout and
//             a mid-entry idle timeout.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             rdy, keypress   - one-cycle key strobe and key code
//             locked          - current lock state (1 = locked)
//             unlock_pulse    - one cycle on a successful lock/unlock toggle
//             prog_done       - one cycle on a successful code change
//             err_pulse       - one cycle on every entry to ERR_BLINK/LOCKOUT
//             led_ok, led_err - indication LEDs
//             lockout, busy   - state indications
//             fail_cnt        - consecutive failed code count
//  Revision : 1.0 - initial release
// ============================================================================
module keylock_ctrl_param #(
    parameter int                           KEY_W        = 4,
    parameter int                           CODE_LEN     = 4,
    parameter logic [CODE_LEN*KEY_W-1:0]    DEFAULT_CODE = 16'h1234,
    parameter int                           KEY_LOCK     = 9,
    parameter int                           KEY_PROG     = 8,
    parameter int                           KEY_CANCEL   = 7,
    parameter int                           MAX_FAIL     = 3,
    parameter int                           LOCKOUT_CYC  = 1000,
    parameter int                           TIMEOUT_CYC  = 5000,
    parameter int                           BLINK_CYC    = 50
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rdy,
    input  logic [KEY_W-1:0]                keypress,
    output logic                            locked,
    output logic                            unlock_pulse,
    output logic                            prog_done,
    output logic                            err_pulse,
    output logic                            led_ok,
    output logic                            led_err,
    output logic                            lockout,
    output logic                            busy,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int CODE_W  = CODE_LEN * KEY_W;
    localparam int CNT_W   = $clog2(CODE_LEN + 2);   // must hold CODE_LEN+1
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (LOCKOUT_CYC > TIMEOUT_CYC)
                           ? ((LOCKOUT_CYC > BLINK_CYC) ? LOCKOUT_CYC : BLINK_CYC)
                           : ((TIMEOUT_CYC > BLINK_CYC) ? TIMEOUT_CYC : BLINK_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [KEY_W-1:0]  C_KEY_LOCK   = KEY_W'(KEY_LOCK);
    localparam logic [KEY_W-1:0]  C_KEY_PROG   = KEY_W'(KEY_PROG);
    localparam logic [KEY_W-1:0]  C_KEY_CANCEL = KEY_W'(KEY_CANCEL);
    localparam logic [CNT_W-1:0]  C_CNT_FULL   = CNT_W'(CODE_LEN);
    localparam logic [CNT_W-1:0]  C_CNT_SAT    = CNT_W'(CODE_LEN + 1);
    localparam logic [FAIL_W-1:0] C_FAIL_MAX   = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  C_BLINK_END  = TMR_W'(BLINK_CYC - 1);
    localparam logic [TMR_W-1:0]  C_LOCK_END   = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  C_TOUT_END   = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENTER     = 3'd1,
        S_PROG_OLD  = 3'd2,
        S_PROG_NEW  = 3'd3,
        S_PROG_CONF = 3'd4,
        S_OK_BLINK  = 3'd5,
        S_ERR_BLINK = 3'd6,
        S_LOCKOUT   = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic                locked_q, locked_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   new_q, new_d;
    logic [CODE_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                unlock_q, unlock_d;
    logic                prog_q, prog_d;
    logic                err_q, err_d;
    logic                led_ok_q, led_err_q, lockout_q, busy_q;

    logic                w_is_digit;
    logic                w_len_ok;
    logic                w_code_ok;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic                w_entry_st;

    assign w_is_digit = (keypress != C_KEY_LOCK) && (keypress != C_KEY_PROG) &&
                        (keypress != C_KEY_CANCEL);
    // Extra digits push the count to CODE_LEN+1, so an overlong entry never matches.
    assign w_len_ok   = (cnt_q == C_CNT_FULL);
    assign w_code_ok  = w_len_ok && (buf_q == code_q);
    assign w_fail_inc = fail_q + FAIL_W'(1);
    assign w_entry_st = (state_q == S_ENTER) || (state_q == S_PROG_OLD) ||
                        (state_q == S_PROG_NEW) || (state_q == S_PROG_CONF);

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        code_d   = code_q;
        new_d    = new_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        tmr_d    = tmr_q;
        unlock_d = 1'b0;
        prog_d   = 1'b0;

        if (w_entry_st) begin
            if (rdy) begin
                tmr_d = '0;
                if (w_is_digit) begin
                    buf_d = CODE_W'({buf_q, keypress});
                    if (cnt_q != C_CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (tmr_q == C_TOUT_END) begin
                state_d = S_ERR_BLINK;
                new_d   = '0;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rdy && keypress == C_KEY_LOCK) begin
                    state_d = S_ENTER;
                end else if (rdy && keypress == C_KEY_PROG) begin
                    state_d = locked_q ? S_ERR_BLINK : S_PROG_OLD;
                end
            end
            S_ENTER: begin
                if (rdy && keypress == C_KEY_CANCEL) begin
                    state_d = S_ERR_BLINK;
                end else if (rdy && keypress == C_KEY_LOCK) begin
                    if (w_code_ok) begin
                        locked_d = ~locked_q;
                        unlock_d = 1'b1;
                        fail_d   = '0;
                        state_d  = S_OK_BLINK;
                    end else begin
                        fail_d  = w_fail_inc;
                        state_d = (w_fail_inc == C_FAIL_MAX) ? S_LOCKOUT : S_ERR_BLINK;
                    end
                end
            end
            S_PROG_OLD: begin
                if (rdy && keypress == C_KEY_CANCEL) begin
                    state_d = S_ERR_BLINK;
                end else if (rdy && keypress == C_KEY_PROG) begin
                    if (w_code_ok) begin
                        state_d = S_PROG_NEW;
                    end else begin
                        fail_d  = w_fail_inc;
                        state_d = (w_fail_inc == C_FAIL_MAX) ? S_LOCKOUT : S_ERR_BLINK;
                    end
                end
            end
            S_PROG_NEW: begin
                if (rdy && keypress == C_KEY_CANCEL) begin
                    state_d = S_ERR_BLINK;
                end else if (rdy && keypress == C_KEY_PROG) begin
                    if (w_len_ok) begin
                        new_d   = buf_q;
                        state_d = S_PROG_CONF;
                    end else begin
                        state_d = S_ERR_BLINK;
                    end
                end
            end
            S_PROG_CONF: begin
                if (rdy && keypress == C_KEY_CANCEL) begin
                    state_d = S_ERR_BLINK;
                end else if (rdy && keypress == C_KEY_PROG) begin
                    if (w_len_ok && buf_q == new_q) begin
                        code_d  = new_q;
                        prog_d  = 1'b1;
                        state_d = S_OK_BLINK;
                    end else begin
                        state_d = S_ERR_BLINK;
                    end
                end
            end
            S_OK_BLINK, S_ERR_BLINK: begin
                if (tmr_q == C_BLINK_END) state_d = S_IDLE;
                else                      tmr_d   = tmr_q + TMR_W'(1);
            end
            S_LOCKOUT: begin
                if (tmr_q == C_LOCK_END) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every state change restarts the shared timer; entering any entry
        // state starts a fresh digit buffer.
        if (state_d != state_q) begin
            tmr_d = '0;
            if (state_d == S_ENTER || state_d == S_PROG_OLD ||
                state_d == S_PROG_NEW || state_d == S_PROG_CONF) begin
                buf_d = '0;
                cnt_d = '0;
            end
        end

        err_d = (state_d != state_q) &&
                (state_d == S_ERR_BLINK || state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            locked_q  <= 1'b1;
            code_q    <= DEFAULT_CODE;
            new_q     <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            tmr_q     <= '0;
            unlock_q  <= 1'b0;
            prog_q    <= 1'b0;
            err_q     <= 1'b0;
            led_ok_q  <= 1'b0;
            led_err_q <= 1'b0;
            lockout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            locked_q  <= locked_d;
            code_q    <= code_d;
            new_q     <= new_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            tmr_q     <= tmr_d;
            unlock_q  <= unlock_d;
            prog_q    <= prog_d;
            err_q     <= err_d;
            // State-decoded outputs are registered from the next state so
            // they line up with the state register.
            led_ok_q  <= (state_d == S_OK_BLINK);
            led_err_q <= (state_d == S_ERR_BLINK) || (state_d == S_LOCKOUT);
            lockout_q <= (state_d == S_LOCKOUT);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign locked       = locked_q;
    assign unlock_pulse = unlock_q;
    assign prog_done    = prog_q;
    assign err_pulse    = err_q;
    assign led_ok       = led_ok_q;
    assign led_err      = led_err_q;
    assign lockout      = lockout_q;
    assign busy         = busy_q;
    assign fail_cnt     = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_keylock_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keylock_ctrl_param
//  Purpose  : Scoreboard bench for keylock_ctrl_param. Stimulus pushes the
//             expected pulse event; a monitor pops and compares whenever the
//             DUT raises unlock_pulse, prog_done or err_pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keylock_ctrl_param;

    localparam logic [2:0] P_UNL = 3'b100;
    localparam logic [2:0] P_PRG = 3'b010;
    localparam logic [2:0] P_ERR = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rdy = 1'b0;
    logic [3:0] keypress = 4'd0;
    logic       locked, unlock_pulse, prog_done, err_pulse;
    logic       led_ok, led_err, lockout, busy;
    logic [1:0] fail_cnt;

    keylock_ctrl_param #(
        .KEY_W(4), .CODE_LEN(4), .DEFAULT_CODE(16'h1234),
        .KEY_LOCK(9), .KEY_PROG(8), .KEY_CANCEL(7), .MAX_FAIL(3),
        .LOCKOUT_CYC(20), .TIMEOUT_CYC(30), .BLINK_CYC(5)
    ) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .keypress(keypress),
        .locked(locked), .unlock_pulse(unlock_pulse), .prog_done(prog_done),
        .err_pulse(err_pulse), .led_ok(led_ok), .led_err(led_err),
        .lockout(lockout), .busy(busy), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [2:0] p;
        logic       lk;
        logic [1:0] fc;
        logic       lo;
    } evt_t;

    evt_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Run-length trackers for the indication outputs.
    int ok_run = 0, ok_last = 0, err_run = 0, err_last = 0, lk_run = 0, lk_last = 0;
    always @(negedge clk) begin
        if (led_ok) ok_run <= ok_run + 1;
        else if (ok_run != 0) begin ok_last <= ok_run; ok_run <= 0; end
        if (led_err) err_run <= err_run + 1;
        else if (err_run != 0) begin err_last <= err_run; err_run <= 0; end
        if (lockout) lk_run <= lk_run + 1;
        else if (lk_run != 0) begin lk_last <= lk_run; lk_run <= 0; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_evt(input int tag, input logic [2:0] p, input logic lk,
                              input logic [1:0] fc, input logic lo);
        evt_t e;
        e.tag = tag; e.p = p; e.lk = lk; e.fc = fc; e.lo = lo;
        sb.push_back(e);
    endtask

    // Monitor: every pulse cycle consumes one expected event.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (!reset && (unlock_pulse || prog_done || err_pulse)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got {unl,prg,err}=%b, expected none",
                             {unlock_pulse, prog_done, err_pulse});
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("evt%0d_pulses", e.tag), 32'({unlock_pulse, prog_done, err_pulse}), 32'(e.p));
                    chk($sformatf("evt%0d_locked", e.tag), 32'(locked), 32'(e.lk));
                    chk($sformatf("evt%0d_fail_cnt", e.tag), 32'(fail_cnt), 32'(e.fc));
                    chk($sformatf("evt%0d_lockout", e.tag), 32'(lockout), 32'(e.lo));
                end
            end
        end
    end

    // Inputs change on the falling edge; each key is followed by one idle cycle.
    task automatic press(input logic [3:0] k);
        rdy = 1'b1;
        keypress = k;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
    endtask

    // Keys packed one per nibble, first key in the most significant used nibble.
    task automatic seq(input logic [63:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) press(s[i*4 +: 4]);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_locked", 32'(locked), 32'd1);
        chk("rst_fail", 32'(fail_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_leds", 32'({led_ok, led_err, lockout}), 32'd0);

        // Overlong entry: last four digits are 1234 but count is five.
        expect_evt(1, P_ERR, 1'b1, 2'd1, 1'b0);
        seq(64'h9112349, 7);
        wait_idle("overlen_idle");
        chk("overlen_err_len", 32'(err_last), 32'd5);

        // Cancel: no fail count.
        expect_evt(2, P_ERR, 1'b1, 2'd1, 1'b0);
        seq(64'h957, 3);
        wait_idle("cancel_idle");
        chk("cancel_fail", 32'(fail_cnt), 32'd1);

        // Two more wrong codes reach MAX_FAIL and lock out.
        expect_evt(3, P_ERR, 1'b1, 2'd2, 1'b0);
        seq(64'h900009, 6);
        wait_idle("wrong2_idle");
        expect_evt(4, P_ERR, 1'b1, 2'd3, 1'b1);
        seq(64'h900009, 6);
        seq(64'h91, 2);                      // ignored during lockout
        wait_idle("lockout_idle");
        chk("lockout_len", 32'(lk_last), 32'd20);
        chk("lockout_led_err_len", 32'(err_last), 32'd20);
        chk("lockout_fail_clr", 32'(fail_cnt), 32'd0);

        // Correct code unlocks.
        expect_evt(5, P_UNL, 1'b0, 2'd0, 1'b0);
        seq(64'h912349, 6);
        wait_idle("unlock_idle");
        chk("unlock_ok_len", 32'(ok_last), 32'd5);

        // Reprogram to 5601, lock with it, old code now fails.
        expect_evt(6, P_PRG, 1'b0, 2'd0, 1'b0);
        seq(64'h8123485601856018, 16);
        wait_idle("prog_idle");
        expect_evt(7, P_UNL, 1'b1, 2'd0, 1'b0);
        seq(64'h956019, 6);
        wait_idle("newcode_idle");
        expect_evt(8, P_ERR, 1'b1, 2'd1, 1'b0);
        seq(64'h912349, 6);
        wait_idle("oldcode_idle");

        // Reset restores DEFAULT_CODE.
        pulse_reset();
        chk("rst2_fail", 32'(fail_cnt), 32'd0);
        chk("rst2_locked", 32'(locked), 32'd1);
        expect_evt(9, P_UNL, 1'b0, 2'd0, 1'b0);
        seq(64'h912349, 6);
        wait_idle("revert_idle");

        // Bad confirm leaves the code at 1234.
        expect_evt(10, P_ERR, 1'b0, 2'd0, 1'b0);
        seq(64'h8123485601856028, 16);
        wait_idle("badconf_idle");
        expect_evt(11, P_UNL, 1'b1, 2'd0, 1'b0);
        seq(64'h912349, 6);
        wait_idle("badconf_relock_idle");

        // KEY_PROG while locked: error, fail count untouched.
        expect_evt(12, P_ERR, 1'b1, 2'd1, 1'b0);
        seq(64'h900009, 6);
        wait_idle("wrong_idle");
        expect_evt(13, P_ERR, 1'b1, 2'd1, 1'b0);
        press(4'd8);
        wait_idle("lockedprog_idle");
        chk("lockedprog_fail", 32'(fail_cnt), 32'd1);

        // Timeout: a key on the expiry edge wins and restarts the timer.
        press(4'd9);
        repeat (28) @(negedge clk);
        press(4'd1);
        repeat (27) @(negedge clk);
        chk("timeout_not_early_busy", 32'(busy), 32'd1);
        chk("timeout_not_early_sb", 32'(sb.size()), 32'd0);
        expect_evt(14, P_ERR, 1'b1, 2'd1, 1'b0);
        wait_idle("timeout_idle");

        // Reset in the middle of a lockout.
        expect_evt(15, P_UNL, 1'b0, 2'd0, 1'b0);
        seq(64'h912349, 6);
        wait_idle("pre_lk_unlock_idle");
        expect_evt(16, P_ERR, 1'b0, 2'd1, 1'b0);
        seq(64'h900009, 6);
        wait_idle("pre_lk1_idle");
        expect_evt(17, P_ERR, 1'b0, 2'd2, 1'b0);
        seq(64'h900009, 6);
        wait_idle("pre_lk2_idle");
        expect_evt(18, P_ERR, 1'b0, 2'd3, 1'b1);
        seq(64'h900009, 6);
        repeat (4) @(negedge clk);
        chk("midlock_lockout", 32'(lockout), 32'd1);
        pulse_reset();
        chk("midlock_rst_busy", 32'(busy), 32'd0);
        chk("midlock_rst_locked", 32'(locked), 32'd1);
        chk("midlock_rst_fail", 32'(fail_cnt), 32'd0);
        chk("midlock_rst_leds", 32'({led_ok, led_err, lockout}), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
